// File: rtl/seq_bcd_converter.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3) with valid/ready on both sides.
// Define BCD_LEADING_BLANK_EN to generate per-digit leading-zero blank flags.
module seq_bcd_converter #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      binary_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_blank
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  localparam bit PARAMS_OK = (BIN_W >= 4) && (BIN_W <= 32) &&
                             (pow10(DIGITS) > ((64'd1 << BIN_W) - 64'd1));

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $fatal(1, "seq_bcd_converter: BIN_W must be 4..32 and 10^DIGITS must exceed 2^BIN_W-1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   shift_reg;
  logic [BCD_W-1:0]   acc, acc_adj;
  logic [CNT_W-1:0]   cnt;
  logic               last_cycle;

  // Counter reaching zero marks the transfer cycle, one cycle after the final shift.
  assign last_cycle = (state == SHIFT) && (cnt == '0);

  // NOTE: non-blocking (<=) for every flop so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = SHIFT;
      SHIFT:   if (cnt == '0)  state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    acc_adj = acc;
    for (int d = 0; d < DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
  end

  assign in_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      acc       <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= binary_in;
            acc       <= '0;
            cnt       <= CNT_W'(BIN_W);
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            {acc, shift_reg} <= {acc_adj, shift_reg} << 1;
            cnt              <= cnt - 1'b1;
          end else begin
            bcd_out <= acc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BCD_LEADING_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              upper_zero;

  // Scan from the top digit down; a digit blanks only while everything above it is zero.
  always_comb begin
    blank_next = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (acc[4*i +: 4] == 4'd0);
      blank_next[i] = upper_zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             digit_blank <= '0;
    else if (last_cycle) digit_blank <= blank_next;
  end
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_seq_bcd_converter.sv
// Self-checking bench for seq_bcd_converter: default 16-bit/5-digit instance plus an 8-bit/3-digit one.
// Expected BCD and blank flags come from decimal arithmetic on the input value.
module tb_seq_bcd_converter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
  logic [15:0] a_bin = '0;
  logic [19:0] a_bcd;
  logic [4:0]  a_blank;

  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
  logic [7:0]  b_bin = '0;
  logic [11:0] b_bcd;
  logic [2:0]  b_blank;

  seq_bcd_converter #(.BIN_W(16), .DIGITS(5)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .binary_in(a_bin), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .bcd_out(a_bcd), .digit_blank(a_blank)
  );

  seq_bcd_converter #(.BIN_W(8), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .binary_in(b_bin), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .bcd_out(b_bcd), .digit_blank(b_blank)
  );

  // Decimal digits by repeated division, packed four bits per digit.
  function automatic logic [31:0] ref_bcd(input int unsigned v, input int nd);
    logic [31:0] r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Digit i (i>=1) is a leading zero exactly when the value is below 10^i.
  function automatic logic [7:0] ref_blank(input int unsigned v, input int nd);
    logic [7:0]  r = '0;
    int unsigned p = 1;
    for (int i = 1; i < nd; i++) begin
      p = p * 10;
`ifdef BCD_LEADING_BLANK_EN
      r[i] = (v < p);
`endif
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input logic [15:0] v);
    int lat;
    logic [31:0] t32;
    logic [7:0]  t8;
    logic [19:0] eb;
    logic [4:0]  ebl;
    t32 = ref_bcd(32'(v), 5);
    t8  = ref_blank(32'(v), 5);
    eb  = t32[19:0];
    ebl = t8[4:0];
    lat = 0;
    while (!a_in_ready && lat < 50) begin tick(); lat++; end
    if (!a_in_ready) begin
      total++; bad++;
      $display("FAIL a_wait_ready: in_ready=%0b required=1 (timeout)", a_in_ready);
    end
    a_bin = v; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 40) begin tick(); lat++; end
    total++;
    if (lat !== 17) begin bad++; $display("FAIL a_latency v=%0d: got=%0d required=17", v, lat); end
    total++;
    if (a_bcd !== eb) begin bad++; $display("FAIL a_bcd v=%0d: got=%h required=%h", v, a_bcd, eb); end
    total++;
    if (a_blank !== ebl) begin bad++; $display("FAIL a_blank v=%0d: got=%b required=%b", v, a_blank, ebl); end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL a_release v=%0d: out_valid=%0b in_ready=%0b required 0/1", v, a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_bcd !== '0 || a_blank !== '0) begin
      bad++;
      $display("FAIL reset_a: ov=%0b ir=%0b bcd=%h blank=%b required 0/0/0/0", a_out_valid, a_in_ready, a_bcd, a_blank);
    end
    total++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b0 || b_bcd !== '0 || b_blank !== '0) begin
      bad++;
      $display("FAIL reset_b: ov=%0b ir=%0b bcd=%h blank=%b required 0/0/0/0", b_out_valid, b_in_ready, b_bcd, b_blank);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    total++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: in_ready a=%0b b=%0b required 1/1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_small();
    int lat;
    logic [31:0] t32;
    logic [7:0]  t8;
    logic [7:0]  vals [2];
    vals[0] = 8'd255;
    vals[1] = 8'($urandom_range(0, 255));
    foreach (vals[k]) begin
      t32 = ref_bcd(32'(vals[k]), 3);
      t8  = ref_blank(32'(vals[k]), 3);
      b_bin = vals[k]; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 30) begin tick(); lat++; end
      total++;
      if (lat !== 9) begin bad++; $display("FAIL b_latency v=%0d: got=%0d required=9", vals[k], lat); end
      total++;
      if (b_bcd !== t32[11:0]) begin bad++; $display("FAIL b_bcd v=%0d: got=%h required=%h", vals[k], b_bcd, t32[11:0]); end
      total++;
      if (b_blank !== t8[2:0]) begin bad++; $display("FAIL b_blank v=%0d: got=%b required=%b", vals[k], b_blank, t8[2:0]); end
      b_out_ready = 1'b1;
      tick();
      b_out_ready = 1'b0;
    end
  endtask

  task automatic test_bounds();
    run_a(16'd65535);
    run_a(16'd0);
    run_a(16'd42);
    run_a(16'd9);
    run_a(16'd10000);
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) run_a(16'($urandom_range(0, 65535)));
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] t32;
    logic [15:0] v;
    v = 16'($urandom_range(1, 65535));
    t32 = ref_bcd(32'(v), 5);
    a_bin = v; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 40) begin tick(); lat++; end
    for (int i = 0; i < 20; i++) begin
      total++;
      if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_bcd !== t32[19:0]) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d: ov=%0b ir=%0b bcd=%h required 1/0/%h", i, a_out_valid, a_in_ready, a_bcd, t32[19:0]);
      end
      a_in_valid = (i % 3 == 0);
      a_bin = 16'($urandom_range(0, 65535));
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_bcd !== t32[19:0]) begin
      bad++;
      $display("FAIL bp_release: ov=%0b ir=%0b bcd=%h required 0/1/%h", a_out_valid, a_in_ready, a_bcd, t32[19:0]);
    end
    tick();
    total++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_ignored: ir=%0b ov=%0b required 1/0", a_in_ready, a_out_valid);
    end
  endtask

  task automatic test_reset_mid();
    a_bin = 16'd1234; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_bcd !== '0 || a_blank !== '0) begin
      bad++;
      $display("FAIL rst_mid: ov=%0b ir=%0b bcd=%h blank=%b required 0/0/0/0", a_out_valid, a_in_ready, a_bcd, a_blank);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    total++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_release: ir=%0b ov=%0b required 1/0", a_in_ready, a_out_valid);
    end
    run_a(16'd987);
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [10];
    logic [15:0] exp_q [$];
    logic [31:0] t32;
    int idx = 0, low = 0, done_cnt = 0, cyc = 0;
    bit seen_first = 0, take;
    foreach (vals[k]) vals[k] = 16'($urandom_range(0, 65535));
    vals[3] = 16'd0;
    a_bin = vals[0]; a_in_valid = 1'b1; a_out_ready = 1'b1;
    while (done_cnt < 10 && cyc < 400) begin
      if (a_out_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra: unexpected result bcd=%h", a_bcd);
        end else begin
          t32 = ref_bcd(32'(exp_q.pop_front()), 5);
          if (a_bcd !== t32[19:0]) begin
            bad++;
            $display("FAIL b2b_bcd #%0d: got=%h required=%h", done_cnt, a_bcd, t32[19:0]);
          end
        end
        done_cnt++;
      end
      take = a_in_ready && a_in_valid;
      if (a_in_ready) begin
        if (seen_first && take) begin
          total++;
          if (low !== 18) begin bad++; $display("FAIL b2b_spacing: low_cycles=%0d required=18", low); end
        end
        seen_first = 1;
        low = 0;
        if (take) exp_q.push_back(a_bin);
      end else begin
        low++;
      end
      tick();
      cyc++;
      if (take) begin
        idx++;
        if (idx < 10) a_bin = vals[idx];
        else          a_in_valid = 1'b0;
      end
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    total++;
    if (done_cnt !== 10) begin bad++; $display("FAIL b2b_count: got=%0d required=10 (timeout)", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_small();
    test_bounds();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
